// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, RGB565 field positions, capture state
// encoding and a saturating counter helper used by the capture path.
package vga_pkg;

  // Default 640x480@60 timing, in pixel clocks (horizontal) and lines (vertical)
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;

  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  // RGB565 field positions
  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    LOCKED = 2'd2
  } cap_state_e;

  // Position counters hold at all-ones rather than wrapping, so a missing
  // sync never aliases back into a plausible count.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers one active-low sync line through two flops and
// flags the falling edge of the first-stage value.
//   clk_i   pixel clock
//   rst_ni  asynchronous active-low reset
//   sync_i  raw sync input
//   fall_o  high for one cycle after a 1->0 transition was registered
module vga_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sync_i;
      s2_q <= s1_q;
    end
  end

  assign fall_o = s2_q & ~s1_q;

endmodule

// File: rtl/vga_rx_capture.sv
// vga_rx_capture: samples VGA sync + RGB565 on the pixel clock, locks to the
// frame timing and emits a coordinate-tagged pixel stream.
//   vga_clk, rst_n           pixel clock, async active-low reset
//   VSYNC_Sig, HSYNC_Sig     active-low syncs
//   vga_data                 RGB565 pixel
//   pix_valid/pix_data       captured active-area pixel (locked only)
//   pix_x/pix_y              active-area coordinates
//   sof/eol                  first pixel of frame / last pixel of line
//   locked                   capture FSM is LOCKED
//   h_err/v_err              one-cycle line/frame length error pulses
//   frame_cnt                completed error-free locked frames
module vga_rx_capture
  import vga_pkg::*;
#(
  parameter int unsigned P_H_SYNC   = H_SYNC,
  parameter int unsigned P_H_BACK   = H_BACK,
  parameter int unsigned P_H_ACTIVE = H_ACTIVE,
  parameter int unsigned P_H_FRONT  = H_FRONT,
  parameter int unsigned P_V_SYNC   = V_SYNC,
  parameter int unsigned P_V_BACK   = V_BACK,
  parameter int unsigned P_V_ACTIVE = V_ACTIVE,
  parameter int unsigned P_V_FRONT  = V_FRONT
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        VSYNC_Sig,
  input  logic        HSYNC_Sig,
  input  logic [15:0] vga_data,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        sof,
  output logic        eol,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] frame_cnt
);

  localparam logic [9:0] H_START = 10'(P_H_SYNC + P_H_BACK);
  localparam logic [9:0] H_END   = 10'(P_H_SYNC + P_H_BACK + P_H_ACTIVE);
  localparam logic [9:0] H_LAST  = 10'(P_H_SYNC + P_H_BACK + P_H_ACTIVE + P_H_FRONT - 1);
  localparam logic [9:0] V_START = 10'(P_V_SYNC + P_V_BACK);
  localparam logic [9:0] V_END   = 10'(P_V_SYNC + P_V_BACK + P_V_ACTIVE);
  localparam logic [9:0] V_LAST  = 10'(P_V_SYNC + P_V_BACK + P_V_ACTIVE + P_V_FRONT - 1);
  localparam logic [9:0] X_LAST  = 10'(P_H_ACTIVE - 1);

  logic hs_fall, vs_fall;

  vga_sync_edge u_hs_edge (.clk_i(vga_clk), .rst_ni(rst_n), .sync_i(HSYNC_Sig), .fall_o(hs_fall));
  vga_sync_edge u_vs_edge (.clk_i(vga_clk), .rst_ni(rst_n), .sync_i(VSYNC_Sig), .fall_o(vs_fall));

  cap_state_e  state_q;
  logic [15:0] data_s1_q, data_s2_q;
  logic [9:0]  h_cnt_q, v_cnt_q;
  logic        vs_pend_q, h_armed_q, v_armed_q, seek_ok_q;
  logic        pix_valid_q, sof_q, eol_q, locked_q, h_err_q, v_err_q;
  logic [15:0] pix_data_q, frame_cnt_q;
  logic [9:0]  pix_x_q, pix_y_q;

  logic        v_consume, h_err_d, v_err_d, any_err, pix_valid_d;
  logic [9:0]  pix_x_d, pix_y_d;

  // data_s2_q lines up with h_cnt_q/v_cnt_q: both describe the same pixel.
  always_comb begin
    v_consume   = hs_fall & (vs_pend_q | vs_fall);
    // At an HSYNC fall h_cnt_q still holds the index of the previous line's last pixel.
    h_err_d     = hs_fall & h_armed_q & (h_cnt_q != H_LAST);
    v_err_d     = v_consume & v_armed_q & (v_cnt_q != V_LAST);
    any_err     = h_err_d | v_err_d;
    pix_x_d     = h_cnt_q - H_START;
    pix_y_d     = v_cnt_q - V_START;
    pix_valid_d = (state_q == LOCKED) &&
                  (h_cnt_q >= H_START) && (h_cnt_q < H_END) &&
                  (v_cnt_q >= V_START) && (v_cnt_q < V_END);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_s1_q   <= '0;
      data_s2_q   <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      vs_pend_q   <= 1'b0;
      h_armed_q   <= 1'b0;
      v_armed_q   <= 1'b0;
      seek_ok_q   <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      locked_q    <= 1'b0;
      h_err_q     <= 1'b0;
      v_err_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      data_s1_q <= vga_data;
      data_s2_q <= data_s1_q;

      h_cnt_q <= hs_fall ? '0 : sat_inc(h_cnt_q);
      if (v_consume)    v_cnt_q <= '0;
      else if (hs_fall) v_cnt_q <= sat_inc(v_cnt_q);
      if (v_consume)    vs_pend_q <= 1'b0;
      else if (vs_fall) vs_pend_q <= 1'b1;

      // The first sync of each kind after reset/error only establishes a reference.
      if (hs_fall)   h_armed_q <= 1'b1;
      if (v_consume) v_armed_q <= 1'b1;

      h_err_q <= h_err_d;
      v_err_q <= v_err_d;

      if ((state_q == LOCKED) && v_consume && !v_err_d)
        frame_cnt_q <= frame_cnt_q + 16'd1;

      pix_valid_q <= pix_valid_d;
      pix_data_q  <= data_s2_q;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      sof_q       <= pix_valid_d && (pix_x_d == '0) && (pix_y_d == '0);
      eol_q       <= pix_valid_d && (pix_x_d == X_LAST);

      // SEEK locks only once a checked frame boundary has passed cleanly,
      // so lock needs two complete VSYNC periods after leaving IDLE.
      case (state_q)
        IDLE: begin
          if (vs_fall) begin
            state_q   <= SEEK;
            seek_ok_q <= 1'b0;
          end
        end
        SEEK: begin
          if (vs_fall && seek_ok_q && !any_err) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end else if (any_err) begin
            seek_ok_q <= 1'b0;
          end else if (v_consume && v_armed_q) begin
            seek_ok_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (any_err) begin
            state_q   <= IDLE;
            locked_q  <= 1'b0;
            h_armed_q <= 1'b0;
            v_armed_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign locked    = locked_q;
  assign h_err     = h_err_q;
  assign v_err     = v_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/vga_rx_capture.md
# vga_rx_capture

Receive-side counterpart of the VGA output bundle: samples VSYNC/HSYNC and RGB565 pixel data on the VGA pixel clock, locks to the frame timing, and emits a coordinate-tagged pixel stream with frame/line markers plus timing-error flags. It sits in the testbench/checker path behind the VGA interface as the sink that turns the raw sync-and-colour wires back into frames for scoreboarding.

## Interface
- H_SYNC, 96: HSYNC pulse width, in pixel clocks.
- H_BACK, 48: horizontal back porch.
- H_ACTIVE, 640: active pixels per line.
- H_FRONT, 16: horizontal front porch. H_TOTAL = sum = 800.
- V_SYNC, 2: VSYNC pulse width, in lines.
- V_BACK, 33 / V_ACTIVE, 480 / V_FRONT, 10: vertical porches and active lines. V_TOTAL = 525.
- vga_clk  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- VSYNC_Sig  in  1  vertical sync, active low.
- HSYNC_Sig  in  1  horizontal sync, active low.
- vga_data  in  16  RGB565 pixel: [15:11] R, [10:5] G, [4:0] B.
- pix_valid  out  1  active-area pixel on pix_data, locked only.
- pix_data  out  16  captured RGB565 pixel.
- pix_x  out  10  column within active area, 0..H_ACTIVE-1.
- pix_y  out  10  row within active area, 0..V_ACTIVE-1.
- sof  out  1  with pix_valid on pixel (0,0).
- eol  out  1  with pix_valid on the last pixel of each active line.
- locked  out  1  high in LOCKED state.
- h_err  out  1  one-cycle pulse: measured line length != H_TOTAL.
- v_err  out  1  one-cycle pulse: measured frame length != V_TOTAL lines.
- frame_cnt  out  16  completed, error-free frames since reset; wraps at 0xFFFF -> 0.

## Operation
- Stage 1 registers VSYNC_Sig, HSYNC_Sig, vga_data; stage 2 holds previous syncs for edge detection. Sync edges are falling edges of stage-1 values.
- h_cnt (10 b): cleared to 0 on the cycle an HSYNC fall is detected, else increments, saturating at 1023.
- VSYNC fall sets vs_pend; on the next (or same-cycle) HSYNC fall, v_cnt is cleared to 0 and vs_pend clears; otherwise each HSYNC fall increments v_cnt (saturating at 1023).
- Active pixel: H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE and V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_ACTIVE. pix_x/pix_y = counters minus the offsets.
- States: IDLE (after reset or error), SEEK, LOCKED.
  - IDLE: wait for VSYNC fall -> SEEK.
  - SEEK: on the next VSYNC fall, if no h_err/v_err occurred since entering SEEK -> LOCKED, else stay in SEEK and restart the check.
  - LOCKED: any h_err or v_err -> IDLE in the same cycle as the error pulse.
- h_err: on an HSYNC fall with the previous line length != H_TOTAL. The first HSYNC fall after reset/IDLE is not checked.
- v_err: on the HSYNC fall consuming vs_pend when the lines since the previous VSYNC != V_TOTAL. The first VSYNC after IDLE is not checked.
- frame_cnt increments on a VSYNC fall accepted in LOCKED without v_err.
- pix_valid, sof, eol are asserted only in LOCKED; in IDLE/SEEK the counters still run but nothing is emitted.

## Timing
- Latency: a pixel on vga_data at edge n appears on pix_data with pix_valid at edge n+2.
- Reset values: all outputs 0; state IDLE; counters 0; vs_pend 0.
- Reset asserted mid-frame: immediate clear. After release, lock needs two full VSYNC periods.
- Simultaneous VSYNC and HSYNC falls: v_cnt is cleared, not incremented.
- Error-to-pixel_valid-low: the cycle after the error pulse. A partially emitted line is not completed.
- Sync glitch shorter than the expected pulse: treated as a real edge and drives an error path.

## Structure
- Shared package vga_pkg: default timing localparams (H_/V_ SYNC/BACK/ACTIVE/FRONT/TOTAL), RGB565 field positions, and the capture state enum typedef (IDLE, SEEK, LOCKED).
- One natural sub-module: vga_sync_edge (2-flop register plus falling-edge pulse), instantiated once per sync.

## Test plan
- Clean 640x480 timing, 3 frames, pixel = {y[4:0], x[5:0], y[4:0]}:
  - frame 1: no pix_valid.
  - from the third VSYNC fall: locked=1, exactly 307200 pix_valid per frame, and data/x/y match.
  - frame_cnt increments once per locked frame.
- While locked, one line shortened to 799 clocks -> h_err pulse at that HSYNC fall; locked=0 and pix_valid=0 from the next cycle; relock after two clean frames.
- VSYNC with 524 lines -> v_err on the consuming HSYNC fall; frame_cnt unchanged; state IDLE.
- VSYNC fall coincident with HSYNC fall vs. 5 clocks earlier -> in both cases the first active line gets pix_y=0 and sof fires at pixel (0,0).
- rst_n pulled low mid-line for 3 clocks:
  - all outputs 0 asynchronously.
  - after release: no pix_valid until after the second following VSYNC fall.
- Force frame_cnt to 0xFFFF (65535 locked frames, or a shortened-parameter build) -> wraps to 0 with no error.
